pipeline_control_unit: RTL and testbench

//  Sequences the 5-stage 16-bit pipeline around the hazard detection unit.

---
 rtl/pipeline_control_unit.sv | 161 ++++++++++++++++
 tb/tb_pipeline_control_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pipeline_control_unit.sv
// Pipeline control unit: merges halt, memory stall, branch flush and load-use stall into per-stage enables.
// Ports: clk/rst; hazard inputs load_use_hazard, branch_taken, mem_req, mem_ready, halt;
//        stage controls pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_bubble, halted;
//        saturating debug counters stall_count, flush_count.
// Latency: controls are combinational from state + inputs; counters update one cycle later.
// Backpressure: an outstanding memory access (mem_req without mem_ready) freezes PC/IF-ID/EX-MEM until mem_ready.
module pipeline_control_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FW-1:0] FL_RELOAD = FW'(FLUSH_CYCLES - 1);
    localparam logic [FW-1:0] FL_LAST   = FW'(1);

    typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT, HALT} state_t;

    state_t           state, state_nx;
    logic             ret_flush, ret_flush_nx;   // 1 = return to FLUSH after MEM_WAIT
    logic [FW-1:0]    flush_left, flush_left_nx;
    logic             branch_acc;                // taken branch accepted this cycle
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic mem_stall;
    assign mem_stall = mem_req && !mem_ready;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            ret_flush  <= 1'b0;
            flush_left <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state      <= state_nx;
            ret_flush  <= ret_flush_nx;
            flush_left <= flush_left_nx;
            // HALT never stalls-counts; the halt-entry cycle does (pc_we=0 outside HALT)
            if (!pc_we && state != HALT && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (branch_acc && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx      = state;
        ret_flush_nx  = ret_flush;
        flush_left_nx = flush_left;
        branch_acc    = 1'b0;
        if (state == HALT || halt) begin
            state_nx = HALT;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        ret_flush_nx = 1'b0;
                        state_nx     = MEM_WAIT;
                    end else if (branch_taken) begin
                        branch_acc = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            flush_left_nx = FL_RELOAD;
                            state_nx      = FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (mem_stall) begin
                        ret_flush_nx = 1'b1;
                        state_nx     = MEM_WAIT;
                    end else if (branch_taken) begin
                        branch_acc    = 1'b1;
                        flush_left_nx = FL_RELOAD;
                        state_nx      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                    end else begin
                        flush_left_nx = flush_left - 1'b1;
                        if (flush_left == FL_LAST)
                            state_nx = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        if (ret_flush) begin
                            // The release cycle is itself one of the flush cycles
                            flush_left_nx = flush_left - 1'b1;
                            state_nx      = (flush_left == FL_LAST) ? RUN : FLUSH;
                        end else begin
                            state_nx = RUN;
                        end
                    end
                end
                default: state_nx = HALT;
            endcase
        end
    end

    // Output logic
    always_comb begin
        pc_we         = 1'b0;
        if_id_we      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_we     = 1'b0;
        mem_wb_bubble = 1'b0;
        halted        = 1'b0;
        if (rst) begin
            // everything held low during reset
        end else if (state == HALT) begin
            halted = 1'b1;
        end else if (halt) begin
            // halt-entry cycle: all enables low
        end else if ((state != MEM_WAIT && mem_stall) || (state == MEM_WAIT && !mem_ready)) begin
            mem_wb_bubble = 1'b1;
        end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            ex_mem_we = 1'b1;
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use_hazard) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                FLUSH: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = branch_taken;
                end
                MEM_WAIT: if_id_flush = ret_flush;
                default: ;
            endcase
        end
    end

    assign stall_count = rst ? '0 : stall_cnt;
    assign flush_count = rst ? '0 : flush_cnt;

endmodule

// File: tb/tb_pipeline_control_unit.sv
module tb_pipeline_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, load_use_hazard, branch_taken, mem_req, mem_ready, halt;
    logic pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_bubble, halted;
    logic [15:0] stall_count, flush_count;
    logic s_pc_we, s_if_id_we, s_if_id_flush, s_id_ex_flush, s_ex_mem_we, s_mem_wb_bubble, s_halted;
    logic [1:0] s_stall_count, s_flush_count;

    pipeline_control_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .halt(halt),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_we(ex_mem_we), .mem_wb_bubble(mem_wb_bubble), .halted(halted),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // Narrow-counter copy on the same stimulus, used for saturation checks
    pipeline_control_unit #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .halt(halt),
        .pc_we(s_pc_we), .if_id_we(s_if_id_we), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .ex_mem_we(s_ex_mem_we), .mem_wb_bubble(s_mem_wb_bubble), .halted(s_halted),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    // {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_bubble, halted}
    localparam logic [6:0] ZERO = 7'b0000000;
    localparam logic [6:0] ADV  = 7'b1100100;
    localparam logic [6:0] LU   = 7'b0001100;
    localparam logic [6:0] BR   = 7'b1111100;
    localparam logic [6:0] FL   = 7'b1110100;
    localparam logic [6:0] FRZ  = 7'b0000010;
    localparam logic [6:0] HLT  = 7'b0000001;

    typedef struct {
        string      tag;
        logic [6:0] vec;
        int         stall;
        int         flush;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    task automatic check(input string tag, input longint obs, input longint expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic h, input logic lu,
                        input logic br, input logic mq, input logic mr, input logic [6:0] ev);
        exp_t e, got;
        logic [6:0] obs;
        rst = r; halt = h; load_use_hazard = lu; branch_taken = br; mem_req = mq; mem_ready = mr;
        e.tag   = tag;
        e.vec   = ev;
        e.stall = r ? 0 : exp_stall;
        e.flush = r ? 0 : exp_flush;
        sb.push_back(e);
        if (r) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (!ev[6] && ev != HLT) exp_stall++;
            if (ev == BR) exp_flush++;
        end
        @(negedge clk);
        got = sb.pop_front();
        obs = {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_bubble, halted};
        check({got.tag, ".vec"}, longint'(obs), longint'(got.vec));
        check({got.tag, ".stall"}, longint'(stall_count), longint'(got.stall));
        check({got.tag, ".flush"}, longint'(flush_count), longint'(got.flush));
        check({got.tag, ".sat_stall"}, longint'(s_stall_count), longint'(got.stall > 3 ? 3 : got.stall));
        check({got.tag, ".sat_flush"}, longint'(s_flush_count), longint'(got.flush > 3 ? 3 : got.flush));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; halt = 1'b0; load_use_hazard = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        //         tag         rst h  lu br mq mr expected
        step("rst0",      1, 0, 0, 0, 0, 0, ZERO);
        step("rst1",      1, 0, 0, 0, 0, 0, ZERO);
        step("idle0",     0, 0, 0, 0, 0, 0, ADV);
        step("idle1",     0, 0, 0, 0, 0, 0, ADV);
        step("rdy_noreq", 0, 0, 0, 0, 0, 1, ADV);
        // load-use: one bubble per asserted cycle
        step("lu0",       0, 0, 1, 0, 0, 0, LU);
        step("lu1",       0, 0, 1, 0, 0, 0, LU);
        step("lu_after",  0, 0, 0, 0, 0, 0, ADV);
        // taken branch, FLUSH_CYCLES=2
        step("br0",       0, 0, 1, 1, 0, 0, BR);
        step("br_fl",     0, 0, 0, 0, 0, 0, FL);
        step("br_run",    0, 0, 0, 0, 0, 0, ADV);
        // memory stall beats branch; branch re-presented after release
        step("mw_frz0",   0, 0, 0, 1, 1, 0, FRZ);
        step("mw_frz1",   0, 0, 1, 1, 1, 0, FRZ);
        step("mw_frz2",   0, 0, 0, 1, 1, 0, FRZ);
        step("mw_rdy",    0, 0, 0, 1, 1, 1, ADV);
        step("mw_br",     0, 0, 0, 1, 0, 0, BR);
        step("mw_fl",     0, 0, 0, 0, 0, 0, FL);
        step("mw_run",    0, 0, 0, 0, 0, 0, ADV);
        // memory stall during FLUSH holds flush_left
        step("fm_br",     0, 0, 0, 1, 0, 0, BR);
        step("fm_frz",    0, 0, 0, 0, 1, 0, FRZ);
        step("fm_rdy",    0, 0, 0, 0, 1, 1, FL);
        step("fm_run",    0, 0, 0, 0, 0, 0, ADV);
        // branch in FLUSH restarts the flush
        step("rb_br0",    0, 0, 0, 1, 0, 0, BR);
        step("rb_br1",    0, 0, 0, 1, 0, 0, BR);
        step("rb_fl",     0, 0, 0, 0, 0, 0, FL);
        step("rb_run",    0, 0, 0, 0, 0, 0, ADV);
        // load-use ignored in FLUSH
        step("lf_br",     0, 0, 0, 1, 0, 0, BR);
        step("lf_lu",     0, 0, 1, 0, 0, 0, FL);
        step("lf_run",    0, 0, 0, 0, 0, 0, ADV);
        // halt beats memory stall, then inputs ignored until reset
        step("h_enter",   0, 1, 1, 1, 1, 0, ZERO);
        step("h_0",       0, 0, 0, 0, 0, 0, HLT);
        step("h_1",       0, 0, 1, 1, 1, 0, HLT);
        step("h_2",       0, 1, 0, 1, 1, 1, HLT);
        step("h_3",       0, 0, 1, 0, 0, 1, HLT);
        step("h_rst",     1, 0, 0, 0, 0, 0, ZERO);
        step("h_idle",    0, 0, 0, 0, 0, 0, ADV);
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
